// File: rtl/rx_frame_checker.sv
// rx_frame_checker
//   GMII receive frame checker. Strips preamble/SFD, forwards frame bytes
//   through a one-byte skid register, and at end of frame reports length,
//   good/bad verdict and updates the good/bad frame counters.
//
//   Optional feature macro: RX_CRC_CHECK_EN
//     defined   -> CRC-32 (reflected 0xEDB88320) over all DATA bytes incl.
//                  FCS; a residue other than 0xDEBB20E3 marks the frame bad.
//     undefined -> verdict depends on length only; no CRC logic.
//
//   Ports
//     GTX_CLK        receive clock, rising edge
//     mr_main_reset  asynchronous active-low reset
//     RX_DV, RXD     GMII receive data valid / byte
//     out_data       frame byte (preamble/SFD stripped)
//     out_valid      out_data valid this cycle
//     out_sof        first byte after SFD (with out_valid)
//     out_eof        last byte of the frame (with out_valid)
//     frame_err      frame verdict, 1 = bad (with out_eof)
//     frame_len      byte count of ending frame, saturates at 2047 (with out_eof)
//     frame_cnt      good-frame counter, saturating
//     err_cnt        bad-frame / aborted-preamble counter, saturating
module rx_frame_checker #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        GTX_CLK,
    input  logic        mr_main_reset,
    input  logic        RX_DV,
    input  logic [7:0]  RXD,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic        frame_err,
    output logic [10:0] frame_len,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    localparam logic [10:0] MIN_L = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L = 11'(MAX_LEN);

    state_t      state;
    logic [2:0]  pre_cnt;    // 0x55 bytes seen so far in this preamble
    logic        armed;      // low only until the first edge after reset
    logic [7:0]  skid_data;
    logic        skid_full;
    logic        skid_sof;
    logic [10:0] byte_cnt;   // bytes sampled in DATA, including the held one
    logic        len_bad;
    logic        crc_bad;
    logic        verdict;

    function automatic logic [15:0] inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [10:0] inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

`ifdef RX_CRC_CHECK_EN
    logic [31:0] crc;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int unsigned i = 0; i < 8; i++) begin
            if (r[0] ^ d[i])
                r = (r >> 1) ^ 32'hEDB88320;
            else
                r = r >> 1;
        end
        return r;
    endfunction

    assign crc_bad = (crc != 32'hDEBB20E3);
`else
    assign crc_bad = 1'b0;
`endif

    assign len_bad = (byte_cnt < MIN_L) || (byte_cnt > MAX_L);
    assign verdict = len_bad | crc_bad;

    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state     <= IDLE;
            pre_cnt   <= '0;
            armed     <= 1'b0;
            skid_data <= '0;
            skid_full <= 1'b0;
            skid_sof  <= 1'b0;
            byte_cnt  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            frame_err <= 1'b0;
            frame_len <= '0;
            frame_cnt <= '0;
            err_cnt   <= '0;
`ifdef RX_CRC_CHECK_EN
            crc       <= '0;
`endif
        end else begin
            armed     <= 1'b1;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            frame_err <= 1'b0;
            frame_len <= '0;

            case (state)
                IDLE: begin
                    if (RX_DV) begin
                        // Data already flowing when reset released: we joined
                        // mid-stream, so wait it out silently.
                        if (!armed) begin
                            state <= DROP;
                        end else if (RXD == 8'h55) begin
                            state   <= PREAMBLE;
                            pre_cnt <= 3'd1;
                        end else begin
                            state   <= DROP;
                            err_cnt <= inc16(err_cnt);
                        end
                    end
                end

                PREAMBLE: begin
                    if (!RX_DV) begin
                        state   <= IDLE;
                        err_cnt <= inc16(err_cnt);
                    end else if (RXD == 8'hD5) begin
                        state     <= DATA;
                        skid_full <= 1'b0;
                        byte_cnt  <= '0;
`ifdef RX_CRC_CHECK_EN
                        crc       <= '1;
`endif
                    end else if (RXD == 8'h55 && pre_cnt < 3'd7) begin
                        pre_cnt <= pre_cnt + 3'd1;
                    end else begin
                        state   <= DROP;
                        err_cnt <= inc16(err_cnt);
                    end
                end

                DATA: begin
                    if (RX_DV) begin
                        if (skid_full) begin
                            out_data  <= skid_data;
                            out_valid <= 1'b1;
                            out_sof   <= skid_sof;
                        end
                        skid_data <= RXD;
                        skid_full <= 1'b1;
                        skid_sof  <= !skid_full;
                        byte_cnt  <= inc11(byte_cnt);
`ifdef RX_CRC_CHECK_EN
                        crc       <= crc_byte(crc, RXD);
`endif
                    end else begin
                        state     <= IDLE;
                        skid_full <= 1'b0;
                        if (skid_full) begin
                            out_data  <= skid_data;
                            out_valid <= 1'b1;
                            out_sof   <= skid_sof;
                            out_eof   <= 1'b1;
                            frame_err <= verdict;
                            frame_len <= byte_cnt;
                            if (verdict)
                                err_cnt <= inc16(err_cnt);
                            else
                                frame_cnt <= inc16(frame_cnt);
                        end else begin
                            // SFD immediately followed by end of carrier.
                            err_cnt <= inc16(err_cnt);
                        end
                    end
                end

                DROP: begin
                    if (!RX_DV)
                        state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
